// File: rtl/hex_entry_buffer_pkg.sv
// Shared types and constants for the hex entry front end.
//   NIBBLE_W : width of one hex digit
//   state_e  : entry FSM states (ENTRY, FULL, DONE)
package hex_entry_pkg;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,  // collecting digits, count < DIGITS
        FULL  = 2'd1,  // count == DIGITS, waiting for confirm/backspace/clear
        DONE  = 2'd2   // word published, buffer empty
    } state_e;
endpackage

// File: rtl/hex_entry_buffer_if.sv
// Bus between the switch/button bank and the entry buffer.
//   switches, enter, backspace, clear, confirm : raw inputs (master -> slave)
//   entry_buf, digit_count, full, overrun      : live entry status (slave -> master)
//   value, value_valid                         : published word (slave -> master)
//
// Handshake: value/value_valid is a valid-only strobe with no ready; value_valid is
// high for exactly one clock when value changes and value holds until the next
// publish, so a consumer may sample value at any time and must treat value_valid as
// a single-cycle event. Buttons are raw levels with no handshake at all.
interface hex_entry_buffer_if
    import hex_entry_pkg::*;
#(
    parameter int DIGITS = 4
);
    localparam int W  = NIBBLE_W * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic [NIBBLE_W-1:0] switches;
    logic                enter;
    logic                backspace;
    logic                clear;
    logic                confirm;
    logic [W-1:0]        entry_buf;
    logic [CW-1:0]       digit_count;
    logic                full;
    logic                overrun;
    logic [W-1:0]        value;
    logic                value_valid;

    modport master (
        output switches, enter, backspace, clear, confirm,
        input  entry_buf, digit_count, full, overrun, value, value_valid
    );

    modport slave (
        input  switches, enter, backspace, clear, confirm,
        output entry_buf, digit_count, full, overrun, value, value_valid
    );
endinterface

// File: rtl/hex_entry_buffer_button_conditioner.sv
// Raw push-button to single-cycle press pulse.
//   clk, rst : clock and asynchronous active-high reset
//   raw      : asynchronous button level
//   pulse    : one-cycle strobe on each debounced rising edge
// Path: 2-FF synchroniser -> debounce (level accepted after DEBOUNCE_CYCLES equal
// synced samples that differ from the current level) -> registered edge detect.
// Raw edge to pulse is DEBOUNCE_CYCLES+3 cycles.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            pulse   <= level & ~level_d;
            // cnt counts consecutive synced samples disagreeing with level; any
            // agreeing sample restarts it, so short glitches never get through.
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/hex_entry_buffer.sv
// Hex word entry front end: collects DIGITS nibbles from a switch bank on debounced
// button presses, supports backspace/clear, flags overrun, and publishes the word.
//   clk100mhz : system clock
//   reset     : asynchronous active-high reset
//   bus       : hex_entry_buffer_if slave (buttons, switches, entry status, value)
//   state_dbg : current FSM state
module hex_entry_buffer
    import hex_entry_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit ALLOW_PARTIAL   = 1'b0
) (
    input  logic                 clk100mhz,
    input  logic                 reset,
    hex_entry_buffer_if.slave    bus,
    output state_e               state_dbg
);
    localparam int W  = NIBBLE_W * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DIGITS);

    logic enter_p, backspace_p, clear_p, confirm_p;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk(clk100mhz), .rst(reset), .raw(bus.enter), .pulse(enter_p));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_backspace (
        .clk(clk100mhz), .rst(reset), .raw(bus.backspace), .pulse(backspace_p));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clk100mhz), .rst(reset), .raw(bus.clear), .pulse(clear_p));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
        .clk(clk100mhz), .rst(reset), .raw(bus.confirm), .pulse(confirm_p));

    state_e              state;
    logic [W-1:0]        entry_buf;
    logic [CW-1:0]       count;
    logic                overrun;
    logic [W-1:0]        value;
    logic                value_valid;
    logic [NIBBLE_W-1:0] sw_s1;
    logic [NIBBLE_W-1:0] sw_s2;
    logic [CW-1:0]       count_inc;
    logic                can_publish;

    assign count_inc   = count + 1'b1;
    assign can_publish = (state == FULL) ||
                         (ALLOW_PARTIAL && (state == ENTRY) && (count != '0));

    always_ff @(posedge clk100mhz or posedge reset) begin
        if (reset) begin
            state       <= ENTRY;
            entry_buf   <= '0;
            count       <= '0;
            overrun     <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            sw_s1       <= '0;
            sw_s2       <= '0;
        end else begin
            sw_s1       <= bus.switches;
            sw_s2       <= sw_s1;
            value_valid <= 1'b0;
            // One action per cycle, clear > confirm > backspace > enter.
            if (clear_p) begin
                entry_buf <= '0;
                count     <= '0;
                overrun   <= 1'b0;
                state     <= ENTRY;
            end else if (confirm_p) begin
                if (can_publish) begin
                    // Digits beyond count are always zero, so a partial word is
                    // already right-aligned and zero-extended.
                    value       <= entry_buf;
                    value_valid <= 1'b1;
                    entry_buf   <= '0;
                    count       <= '0;
                    overrun     <= 1'b0;
                    state       <= DONE;
                end
            end else if (backspace_p) begin
                // DONE always has count 0, so the count test also ignores it there.
                if (count != '0) begin
                    entry_buf <= entry_buf >> NIBBLE_W;
                    count     <= count - 1'b1;
                    overrun   <= 1'b0;
                    state     <= ENTRY;
                end
            end else if (enter_p) begin
                if (state == FULL) begin
                    overrun <= 1'b1;
                end else begin
                    // DONE has an empty buffer, so the same shift covers ENTRY and DONE.
                    entry_buf <= (entry_buf << NIBBLE_W) | W'(sw_s2);
                    count     <= count_inc;
                    state     <= (count_inc == COUNT_FULL) ? FULL : ENTRY;
                end
            end
        end
    end

    assign bus.entry_buf   = entry_buf;
    assign bus.digit_count = count;
    assign bus.full        = (state == FULL);
    assign bus.overrun     = overrun;
    assign bus.value       = value;
    assign bus.value_valid = value_valid;
    assign state_dbg       = state;
endmodule

// File: tb/tb_hex_entry_buffer.sv
module tb_hex_entry_buffer;
    import hex_entry_pkg::*;

    localparam int DIGITS = 4;
    localparam int DEB    = 4;
    localparam int W      = 16;
    localparam int CW     = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    logic [3:0] sw      = 4'h0;
    logic       b_enter = 1'b0;
    logic       b_bksp  = 1'b0;
    logic       b_clear = 1'b0;
    logic       b_conf  = 1'b0;

    hex_entry_buffer_if #(.DIGITS(DIGITS)) bus ();
    hex_entry_buffer_if #(.DIGITS(DIGITS)) bus_p ();

    assign bus.switches    = sw;
    assign bus.enter       = b_enter;
    assign bus.backspace   = b_bksp;
    assign bus.clear       = b_clear;
    assign bus.confirm     = b_conf;
    assign bus_p.switches  = sw;
    assign bus_p.enter     = b_enter;
    assign bus_p.backspace = b_bksp;
    assign bus_p.clear     = b_clear;
    assign bus_p.confirm   = b_conf;

    state_e st;
    state_e st_p;

    hex_entry_buffer #(.DIGITS(DIGITS), .DEBOUNCE_CYCLES(DEB), .ALLOW_PARTIAL(1'b0)) dut (
        .clk100mhz(clk), .reset(reset), .bus(bus), .state_dbg(st));
    hex_entry_buffer #(.DIGITS(DIGITS), .DEBOUNCE_CYCLES(DEB), .ALLOW_PARTIAL(1'b1)) dut_p (
        .clk100mhz(clk), .reset(reset), .bus(bus_p), .state_dbg(st_p));

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_p_q[$];
    bit           chk_p = 1'b0;
    logic [W-1:0] mon_e;
    logic [W-1:0] mon_pe;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.value_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe: unexpected value_valid with value %h, expected no strobe", bus.value);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.value !== mon_e) begin
                    n_fail++;
                    $display("FAIL strobe_value: got %h expected %h", bus.value, mon_e);
                end
            end
        end
        if (!reset && chk_p && bus_p.value_valid) begin
            n_cmp++;
            if (exp_p_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_p: unexpected value_valid with value %h, expected no strobe", bus_p.value);
            end else begin
                mon_pe = exp_p_q.pop_front();
                if (bus_p.value !== mon_pe) begin
                    n_fail++;
                    $display("FAIL strobe_p_value: got %h expected %h", bus_p.value, mon_pe);
                end
            end
        end
    end

    // ---------------- driver ----------------
    typedef enum {OP_ENTER, OP_BKSP, OP_CLEAR, OP_CONF} op_e;

    task automatic set_btn(input op_e op, input logic v);
        case (op)
            OP_ENTER: b_enter = v;
            OP_BKSP:  b_bksp  = v;
            OP_CLEAR: b_clear = v;
            default:  b_conf  = v;
        endcase
    endtask

    // Hold a button for 'hold' cycles, then leave a 20-cycle gap so both the press
    // and the release have fully debounced before anything is sampled.
    task automatic press(input op_e op, input logic [3:0] s, input int hold);
        sw = s;
        @(negedge clk);
        set_btn(op, 1'b1);
        repeat (hold) @(negedge clk);
        set_btn(op, 1'b0);
        repeat (20) @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        op_e           op;
        logic [3:0]    sw;
        logic [W-1:0]  exp_buf;
        logic [CW-1:0] exp_cnt;
        logic          exp_full;
        logic          exp_ovr;
        logic          pub;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(op_e op, logic [3:0] s, logic [W-1:0] b, int c,
                                bit f, bit o, bit p);
        vec_t v;
        v.op = op; v.sw = s; v.exp_buf = b; v.exp_cnt = CW'(c);
        v.exp_full = f; v.exp_ovr = o; v.pub = p;
        return v;
    endfunction

    logic [W-1:0] prev_buf;
    logic [W-1:0] last_value;

    initial begin
        // entry F,D,6,C then confirm
        vecs.push_back(mk(OP_ENTER, 4'hF, 16'h000F, 1, 0, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'hD, 16'h00FD, 2, 0, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'h6, 16'h0FD6, 3, 0, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'hC, 16'hFD6C, 4, 1, 0, 0));
        vecs.push_back(mk(OP_CONF,  4'h0, 16'h0000, 0, 0, 0, 1));
        // 8,0,0,0 then overrun with 7, then confirm
        vecs.push_back(mk(OP_ENTER, 4'h8, 16'h0008, 1, 0, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'h0, 16'h0080, 2, 0, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'h0, 16'h0800, 3, 0, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'h0, 16'h8000, 4, 1, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'h7, 16'h8000, 4, 1, 1, 0));
        vecs.push_back(mk(OP_CONF,  4'h0, 16'h0000, 0, 0, 0, 1));
        // backspace handling
        vecs.push_back(mk(OP_ENTER, 4'h3, 16'h0003, 1, 0, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'hA, 16'h003A, 2, 0, 0, 0));
        vecs.push_back(mk(OP_BKSP,  4'h0, 16'h0003, 1, 0, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'h5, 16'h0035, 2, 0, 0, 0));
        vecs.push_back(mk(OP_BKSP,  4'h0, 16'h0003, 1, 0, 0, 0));
        vecs.push_back(mk(OP_BKSP,  4'h0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(OP_BKSP,  4'h0, 16'h0000, 0, 0, 0, 0));
        // backspace out of FULL clears overrun; clear discards
        vecs.push_back(mk(OP_ENTER, 4'h1, 16'h0001, 1, 0, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'h2, 16'h0012, 2, 0, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'h3, 16'h0123, 3, 0, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'h4, 16'h1234, 4, 1, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'h5, 16'h1234, 4, 1, 1, 0));
        vecs.push_back(mk(OP_BKSP,  4'h0, 16'h0123, 3, 0, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'h9, 16'h1239, 4, 1, 0, 0));
        vecs.push_back(mk(OP_CLEAR, 4'h0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(OP_CONF,  4'h0, 16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(OP_ENTER, 4'h7, 16'h0007, 1, 0, 0, 0));
        vecs.push_back(mk(OP_CONF,  4'h0, 16'h0007, 1, 0, 0, 0));
        vecs.push_back(mk(OP_CLEAR, 4'h0, 16'h0000, 0, 0, 0, 0));

        // reset state
        repeat (5) @(negedge clk);
        check("rst_buf", bus.entry_buf, '0);
        check("rst_cnt", W'(bus.digit_count), '0);
        check("rst_full", W'(bus.full), '0);
        check("rst_value", bus.value, '0);
        check("rst_state", W'(st), W'(ENTRY));
        reset = 1'b0;
        repeat (3) @(negedge clk);

        prev_buf   = '0;
        last_value = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].pub) begin
                exp_q.push_back(prev_buf);
                last_value = prev_buf;
            end
            press(vecs[i].op, vecs[i].sw, 20);
            check($sformatf("v%0d_buf", i), bus.entry_buf, vecs[i].exp_buf);
            check($sformatf("v%0d_cnt", i), W'(bus.digit_count), W'(vecs[i].exp_cnt));
            check($sformatf("v%0d_full", i), W'(bus.full), W'(vecs[i].exp_full));
            check($sformatf("v%0d_ovr", i), W'(bus.overrun), W'(vecs[i].exp_ovr));
            check($sformatf("v%0d_value", i), bus.value, last_value);
            prev_buf = vecs[i].exp_buf;
        end

        // reset mid-entry is asynchronous
        press(OP_ENTER, 4'h1, 20);
        press(OP_ENTER, 4'h2, 20);
        check("mid_cnt", W'(bus.digit_count), W'(2));
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_buf", bus.entry_buf, '0);
        check("async_cnt", W'(bus.digit_count), '0);
        check("async_value", bus.value, '0);
        check("async_ovr", W'(bus.overrun), '0);
        check("async_state", W'(st), W'(ENTRY));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        press(OP_ENTER, 4'h0, 20);
        press(OP_ENTER, 4'h1, 20);
        press(OP_ENTER, 4'hB, 20);
        press(OP_ENTER, 4'hA, 20);
        check("t2_buf", bus.entry_buf, 16'h01BA);
        exp_q.push_back(16'h01BA);
        press(OP_CONF, 4'h0, 20);
        check("t2_value", bus.value, 16'h01BA);
        check("t2_cnt", W'(bus.digit_count), '0);
        check("t2_state", W'(st), W'(DONE));

        // 2-cycle glitch on enter is filtered
        @(negedge clk);
        sw = 4'h6;
        b_enter = 1'b1;
        repeat (2) @(negedge clk);
        b_enter = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_cnt", W'(bus.digit_count), '0);
        check("glitch_buf", bus.entry_buf, '0);

        // long holds produce a single action
        press(OP_ENTER, 4'h1, 20);
        press(OP_ENTER, 4'h2, 20);
        press(OP_ENTER, 4'h3, 20);
        press(OP_ENTER, 4'h4, 20);
        press(OP_BKSP, 4'h0, 100);
        check("hold_bksp_buf", bus.entry_buf, 16'h0123);
        check("hold_bksp_cnt", W'(bus.digit_count), W'(3));
        press(OP_ENTER, 4'h4, 20);
        exp_q.push_back(16'h1234);
        press(OP_CONF, 4'h0, 100);
        check("hold_conf_value", bus.value, 16'h1234);
        check("hold_conf_cnt", W'(bus.digit_count), '0);

        // partial confirm: published only where ALLOW_PARTIAL=1
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        press(OP_ENTER, 4'h9, 20);
        press(OP_ENTER, 4'hE, 20);
        chk_p = 1'b1;
        exp_p_q.push_back(16'h009E);
        press(OP_CONF, 4'h0, 20);
        check("np_cnt", W'(bus.digit_count), W'(2));
        check("np_buf", bus.entry_buf, 16'h009E);
        check("np_value", bus.value, '0);
        check("p_value", bus_p.value, 16'h009E);
        check("p_cnt", W'(bus_p.digit_count), '0);
        check("p_state", W'(st_p), W'(DONE));

        // ---------------- final report ----------------
        repeat (5) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_strobes: got %0d missing strobes expected 0", exp_q.size());
        end
        n_cmp++;
        if (exp_p_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_strobes_p: got %0d missing strobes expected 0", exp_p_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
